// File: rtl/fp16_normalize.sv
// Final FP16 adder stage: iterative left-normalize of the post-add magnitude,
// round-to-nearest-even, then pack into IEEE-754 half precision.
module fp16_normalize #(
  parameter int unsigned EXP_W  = 5,
  parameter int unsigned FRAC_W = 10,
  parameter int unsigned MW     = FRAC_W + 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic                       in_sign,
  input  logic [EXP_W-1:0]           in_exp,
  input  logic [MW-1:0]              in_mant,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [EXP_W+FRAC_W:0]      out_result
);

  localparam int unsigned XW    = EXP_W + 1;
  localparam int unsigned RES_W = 1 + EXP_W + FRAC_W;
  localparam int unsigned RW    = FRAC_W + 2;
  localparam logic [EXP_W-1:0] EXP_ONES = {EXP_W{1'b1}};
  localparam logic [XW-1:0]    EXP_INF  = XW'(EXP_ONES);

  typedef enum logic [1:0] {IDLE, NORM, ROUND, DONE} state_t;

  state_t             state_q, state_d;
  logic               sign_q, sign_d;
  logic [XW-1:0]      exp_q, exp_d;
  logic [MW-2:0]      mant_q, mant_d;   // carry bit is folded away on capture
  logic [RES_W-1:0]   result_q, result_d;
  logic               in_ready_q, in_ready_d;
  logic               out_valid_q, out_valid_d;

  logic               rnd_up;
  logic [RW-1:0]      rnd_sum;
  logic [XW-1:0]      exp_r;
  logic               hidden_r;
  logic [FRAC_W-1:0]  frac_r;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      sign_q      <= 1'b0;
      exp_q       <= '0;
      mant_q      <= '0;
      result_q    <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sign_q      <= sign_d;
      exp_q       <= exp_d;
      mant_q      <= mant_d;
      result_q    <= result_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    sign_d   = sign_q;
    exp_d    = exp_q;
    mant_d   = mant_q;
    result_d = result_q;

    // Nearest-even increment on {hidden, frac}; bit RW-1 is the rounding carry
    rnd_up   = mant_q[1] & (mant_q[0] | mant_q[2]);
    rnd_sum  = {1'b0, mant_q[MW-2:2]} + RW'(rnd_up);
    exp_r    = exp_q + XW'(rnd_sum[RW-1]);
    hidden_r = rnd_sum[RW-1] ? 1'b1 : rnd_sum[FRAC_W];
    frac_r   = rnd_sum[RW-1] ? rnd_sum[FRAC_W:1] : rnd_sum[FRAC_W-1:0];

    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          sign_d = in_sign;
          exp_d  = XW'(in_exp);
          mant_d = in_mant[MW-2:0];
          if (in_exp == EXP_ONES) begin
            result_d = {in_sign, EXP_ONES, {FRAC_W{1'b0}}};
            state_d  = DONE;
          end else if (in_mant == '0) begin
            result_d = '0;
            state_d  = DONE;
          end else if (in_mant[MW-1]) begin
            mant_d  = {in_mant[MW-1:2], in_mant[1] | in_mant[0]};
            exp_d   = XW'(in_exp) + XW'(1);
            state_d = NORM;
          end else begin
            state_d = NORM;
          end
        end
      end
      NORM: begin
        // exp 1 is the subnormal floor: stop shifting and round as-is
        if (mant_q[MW-2] || exp_q <= XW'(1)) begin
          state_d = ROUND;
        end else begin
          mant_d = {mant_q[MW-3:0], 1'b0};
          exp_d  = exp_q - XW'(1);
        end
      end
      ROUND: begin
        if (exp_r >= EXP_INF) begin
          result_d = {sign_q, EXP_ONES, {FRAC_W{1'b0}}};
        end else begin
          result_d = {sign_q, hidden_r ? exp_r[EXP_W-1:0] : {EXP_W{1'b0}}, frac_r};
        end
        state_d = DONE;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == DONE);
  end

  assign in_ready   = in_ready_q;
  assign out_valid  = out_valid_q;
  assign out_result = result_q;

endmodule

// File: tb/tb_fp16_normalize.sv
// Bench for fp16_normalize: directed cases pinned to literals, then a random
// stream, all checked against an arithmetic reference model every cycle.
module tb_fp16_normalize;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic        in_sign;
  logic [4:0]  in_exp;
  logic [13:0] in_mant;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_result;

  fp16_normalize dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_sign    (in_sign),
    .in_exp     (in_exp),
    .in_mant    (in_mant),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] res;
    int          lat;
    int          acc;
    bit          seen;
  } exp_t;

  exp_t        pend[$];
  int          checks = 0;
  int          passes = 0;
  int          cyc = 0;
  bit          lit_en;
  logic [15:0] lit_res;
  int          lit_lat;
  bit          hold_low;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act === req) passes++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
  endtask

  // Reference: plain integer arithmetic; lat = edges after the transfer edge
  function automatic void model(input logic s, input logic [4:0] ein, input logic [13:0] min,
                                output logic [15:0] res, output int lat);
    int e, m, q, k;
    logic [4:0] ef;
    e = int'(ein);
    m = int'(min);
    k = 0;
    if (e == 31) begin res = {s, 5'h1f, 10'h000}; lat = 0; return; end
    if (m == 0)  begin res = 16'h0000;            lat = 0; return; end
    if (m >= 8192) begin m = (m >> 1) | (m & 1); e++; end
    while (m < 4096 && e > 1) begin m = m * 2; e--; k++; end
    q = m / 4;
    if ((m % 4 == 3) || (m % 4 == 2 && q % 2 == 1)) q++;
    if (q >= 2048) begin q = q / 2; e++; end
    lat = k + 2;
    if (e >= 31) begin
      res = {s, 5'h1f, 10'h000};
    end else begin
      ef  = (q >= 1024) ? 5'(e) : 5'd0;
      res = {s, ef, 10'(q % 1024)};
    end
  endfunction

  // Single compare process: sampled on the falling edge
  always @(negedge clk) begin
    logic [15:0] m_res;
    int          m_lat;
    if (!rst_n) begin
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_result", 32'(out_result), 32'h0);
      pend.delete();
    end else begin
      if (out_valid) begin
        if (pend.size() == 0) begin
          chk("spurious_out_valid", 32'(out_valid), 32'd0);
        end else begin
          if (!pend[0].seen) begin
            chk("latency", 32'(cyc - pend[0].acc), 32'(pend[0].lat));
            pend[0].seen = 1'b1;
          end
          chk("out_result", 32'(out_result), 32'(pend[0].res));
          chk("in_ready_done", 32'(in_ready), 32'd0);
          if (out_ready) void'(pend.pop_front());
        end
      end else if (pend.size() != 0) begin
        chk("in_ready_busy", 32'(in_ready), 32'd0);
        if (cyc - pend[0].acc > 40) begin
          chk("timeout_out_valid", 32'd0, 32'd1);
          void'(pend.pop_front());
        end
      end else begin
        chk("in_ready_idle", 32'(in_ready), 32'd1);
      end
      if (in_valid && in_ready) begin
        model(in_sign, in_exp, in_mant, m_res, m_lat);
        if (lit_en) begin
          chk("model_pin_res", 32'(m_res), 32'(lit_res));
          chk("model_pin_lat", 32'(m_lat), 32'(lit_lat));
        end
        pend.push_back('{res: m_res, lat: m_lat, acc: cyc + 1, seen: 1'b0});
      end
    end
  end

  initial begin
    out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      out_ready = hold_low ? 1'b0 : ($urandom_range(0, 3) != 0);
    end
  end

  // One directed operation; hold>0 keeps out_ready low that many cycles after
  // the result appears; rst_at>0 pulses reset that many cycles after accept.
  task automatic send(input logic s, input logic [4:0] e, input logic [13:0] m,
                      input logic [15:0] r, input int l, input int hold, input int rst_at);
    in_sign  = s;
    in_exp   = e;
    in_mant  = m;
    in_valid = 1'b1;
    lit_en   = (rst_at == 0);
    lit_res  = r;
    lit_lat  = l;
    hold_low = (hold > 0);
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (in_ready) break;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    lit_en   = 1'b0;
    if (rst_at > 0) begin
      repeat (rst_at) @(posedge clk);
      #1;
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
    end else if (hold > 0) begin
      repeat (l + hold) @(posedge clk);
      #1;
      hold_low = 1'b0;
    end
    for (int i = 0; i < 100 && pend.size() != 0; i++) @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_sign  = 1'b0;
    in_exp   = 5'd0;
    in_mant  = 14'd0;
    lit_en   = 1'b0;
    lit_res  = 16'h0;
    lit_lat  = 0;
    hold_low = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    send(1'b0, 5'd15, 14'h1000, 16'h3C00, 2, 5, 0);   // basic normal, with backpressure
    send(1'b0, 5'd15, 14'h2000, 16'h4000, 2, 0, 0);   // carry renormalize
    send(1'b0, 5'd30, 14'h2FFF, 16'h7C00, 2, 0, 0);   // overflow to Inf
    send(1'b0, 5'd15, 14'h0004, 16'h1400, 12, 0, 0);  // 10-shift cancellation
    send(1'b1, 5'd10, 14'h0000, 16'h0000, 0, 0, 0);   // zero, sign dropped
    send(1'b0, 5'd15, 14'h1006, 16'h3C02, 2, 0, 0);   // tie, odd lsb
    send(1'b0, 5'd15, 14'h1002, 16'h3C00, 2, 0, 0);   // tie, even lsb
    send(1'b0, 5'd15, 14'h1FFF, 16'h4000, 2, 0, 0);   // rounding carry-out
    send(1'b0, 5'd2,  14'h0400, 16'h0200, 3, 0, 0);   // subnormal floor
    send(1'b0, 5'd1,  14'h0FFF, 16'h0400, 2, 0, 0);   // subnormal rounds to min normal
    send(1'b1, 5'd31, 14'h1234, 16'hFC00, 0, 0, 0);   // -Inf input
    send(1'b1, 5'd20, 14'h1001, 16'hD000, 2, 0, 0);   // sticky only, no round
    send(1'b0, 5'd15, 14'h0004, 16'h0000, 0, 0, 3);   // reset mid-NORM
    send(1'b0, 5'd15, 14'h1000, 16'h3C00, 2, 0, 0);   // unaffected after reset

    for (int i = 0; i < 4000; i++) begin
      in_valid = ($urandom_range(0, 2) != 0);
      in_sign  = 1'($urandom_range(0, 1));
      in_exp   = 5'($urandom_range(1, 31));
      in_mant  = 14'($urandom_range(0, 16383) >> $urandom_range(0, 13));
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    for (int i = 0; i < 100 && pend.size() != 0; i++) @(posedge clk);
    #1;
    if (pend.size() != 0) chk("drain", 32'(pend.size()), 32'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
